gnt_burst_mux: RTL and testbench

Downstream stage of the 4-way arbiter: consumes `gnt0..gnt3` and moves a fixed-length data burst from the granted client onto a single shared target port with a valid/ready handshake. It tracks burst progress and acknowledges each accepted beat back to the owning client. It pulses a per-client done flag at burst end so the client can drop its request. It flags illegal multi-hot grants.

---
 rtl/gnt_burst_mux.sv | 125 ++++++++++++
 tb/tb_gnt_burst_mux.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gnt_burst_mux.sv
// gnt_burst_mux: moves a fixed-length burst from the granted
// client onto one shared valid/ready target port.
module gnt_burst_mux #(
  parameter int DW    = 8,
  parameter int BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          gnt0,
  input  logic          gnt1,
  input  logic          gnt2,
  input  logic          gnt3,
  input  logic [DW-1:0] din0,
  input  logic [DW-1:0] din1,
  input  logic [DW-1:0] din2,
  input  logic [DW-1:0] din3,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [1:0]    out_src,
  output logic          ack0,
  output logic          ack1,
  output logic          ack2,
  output logic          ack3,
  output logic          done0,
  output logic          done1,
  output logic          done2,
  output logic          done3,
  output logic          busy,
  output logic          err
);

  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CW-1:0] LAST = CW'(BURST - 1);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE
  } state_t;

  state_t        state;
  logic [1:0]    src;
  logic [CW-1:0] beat_cnt;
  logic [3:0]    done_q;

  logic [3:0]    gnt;
  logic [DW-1:0] din [4];
  logic [1:0]    gidx;
  logic          onehot;
  logic          multi;
  logic          accept;
  logic [3:0]    ack;

  assign gnt    = {gnt3, gnt2, gnt1, gnt0};
  assign din[0] = din0;
  assign din[1] = din1;
  assign din[2] = din2;
  assign din[3] = din3;

  always_comb begin
    gidx   = 2'd0;
    onehot = 1'b0;
    unique case (gnt)
      4'b0001: begin gidx = 2'd0; onehot = 1'b1; end
      4'b0010: begin gidx = 2'd1; onehot = 1'b1; end
      4'b0100: begin gidx = 2'd2; onehot = 1'b1; end
      4'b1000: begin gidx = 2'd3; onehot = 1'b1; end
      default: ;
    endcase
  end

  // clearing the lowest set bit leaves something only if 2+ bits were set
  assign multi = (gnt & (gnt - 4'd1)) != 4'd0;

  assign out_valid = (state == XFER) && gnt[src];
  assign accept    = out_valid && out_ready;
  assign out_data  = out_valid ? din[src] : '0;
  assign out_src   = src;
  assign ack       = accept ? (4'b0001 << src) : 4'b0000;

  assign {ack3, ack2, ack1, ack0}     = ack;
  assign {done3, done2, done1, done0} = done_q;
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      src      <= 2'd0;
      beat_cnt <= '0;
      err      <= 1'b0;
      done_q   <= 4'b0000;
    end else begin
      done_q <= 4'b0000;
      unique case (state)
        IDLE: begin
          if (onehot) begin
            src      <= gidx;
            beat_cnt <= '0;
            state    <= XFER;
          end else if (multi) begin
            err <= 1'b1;
          end
        end
        XFER: begin
          if (!gnt[src]) begin
            beat_cnt <= '0;
            state    <= IDLE;
          end else if (accept) begin
            if (beat_cnt == LAST) begin
              beat_cnt <= '0;
              done_q   <= 4'b0001 << src;
              state    <= DONE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gnt_burst_mux.sv
// tb_gnt_burst_mux: table vectors, directed burst sequences and
// random traffic against a transaction-level reference model.
module tb_gnt_burst_mux;

  localparam int DW    = 8;
  localparam int BURST = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    g;
  logic          rdy;
  logic [DW-1:0] d [4];
  wire           ov;
  wire  [DW-1:0] od;
  wire  [1:0]    osrc;
  wire  [3:0]    ack;
  wire  [3:0]    done;
  wire           busy;
  wire           err;

  always #5 clk = ~clk;

  gnt_burst_mux #(.DW(DW), .BURST(BURST)) dut (
    .clk(clk), .rst(rst),
    .gnt0(g[0]), .gnt1(g[1]), .gnt2(g[2]), .gnt3(g[3]),
    .din0(d[0]), .din1(d[1]), .din2(d[2]), .din3(d[3]),
    .out_ready(rdy), .out_valid(ov), .out_data(od),
    .out_src(osrc),
    .ack0(ack[0]), .ack1(ack[1]), .ack2(ack[2]), .ack3(ack[3]),
    .done0(done[0]), .done1(done[1]),
    .done2(done[2]), .done3(done[3]),
    .busy(busy), .err(err)
  );

  int vectors    = 0;
  int miscompares = 0;

  // reference model: who owns the port, beats moved so far,
  // who is owed a done pulse this cycle
  int   m_own   = -1;
  int   m_done  = -1;
  int   m_beats = 0;
  int   m_src   = 0;
  logic m_err   = 1'b0;
  bit   chk     = 1'b0;

  typedef struct {
    logic          rst;
    logic [3:0]    g;
    logic          rdy;
    logic          ev;
    logic [DW-1:0] ed;
    logic [3:0]    eack;
    logic [3:0]    edone;
    logic          eb;
    logic          ee;
  } vec_t;

  vec_t       tbl [10];
  logic [3:0] gs  [12];
  int         n_ack, n_done, n_other;
  int         q[$];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_cmp();
    logic          e_v;
    logic [DW-1:0] e_d;
    logic [3:0]    e_a;
    logic [3:0]    e_dn;
    logic          e_b;
    e_v  = 1'b0;
    e_d  = '0;
    e_a  = 4'b0;
    e_dn = 4'b0;
    if (m_own >= 0) begin
      e_v = g[m_own];
      if (e_v) e_d = d[m_own];
      if (e_v && rdy) e_a[m_own] = 1'b1;
    end
    if (m_done >= 0) e_dn[m_done] = 1'b1;
    e_b = (m_own >= 0) || (m_done >= 0);
    check("valid", 32'(ov), 32'(e_v));
    check("data", 32'(od), 32'(e_d));
    check("src", 32'(osrc), 32'(m_src));
    check("ack", 32'(ack), 32'(e_a));
    check("done", 32'(done), 32'(e_dn));
    check("busy", 32'(busy), 32'(e_b));
    check("err", 32'(err), 32'(m_err));
  endtask

  task automatic model_step();
    int n;
    if (rst) begin
      m_own = -1; m_done = -1; m_beats = 0;
      m_src = 0;  m_err = 1'b0;
    end else if (m_done >= 0) begin
      m_done = -1;
    end else if (m_own >= 0) begin
      if (!g[m_own]) begin
        m_own = -1;
      end else if (rdy) begin
        m_beats++;
        if (m_beats == BURST) begin
          m_done = m_own;
          m_own  = -1;
        end
      end
    end else begin
      n = $countones(g);
      if (n == 1) begin
        for (int i = 0; i < 4; i++)
          if (g[i]) m_own = i;
        m_src   = m_own;
        m_beats = 0;
      end else if (n > 1) begin
        m_err = 1'b1;
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    if (chk) model_cmp();
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time %0t exceeded", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b0, 4'h0, 1'b1, 1'b0, 8'h00, 4'h0, 4'h0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 4'h1, 1'b1, 1'b0, 8'h00, 4'h0, 4'h0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 4'h1, 1'b1, 1'b1, 8'hA5, 4'h1, 4'h0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 4'h1, 1'b1, 1'b1, 8'hA5, 4'h1, 4'h0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 4'h1, 1'b1, 1'b1, 8'hA5, 4'h1, 4'h0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 4'h1, 1'b1, 1'b1, 8'hA5, 4'h1, 4'h0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 4'h0, 1'b1, 1'b0, 8'h00, 4'h0, 4'h1, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 4'h0, 1'b1, 1'b0, 8'h00, 4'h0, 4'h0, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 4'h5, 1'b1, 1'b0, 8'h00, 4'h0, 4'h0, 1'b0, 1'b0};
    tbl[9] = '{1'b0, 4'h0, 1'b1, 1'b0, 8'h00, 4'h0, 4'h0, 1'b0, 1'b1};

    d[0] = 8'hA5; d[1] = 8'h11; d[2] = 8'h22; d[3] = 8'h33;
    rst = 1'b1; g = 4'h0; rdy = 1'b0;
    sample();
    advance();
    chk = 1'b1;

    for (int i = 0; i < 10; i++) begin
      rst = tbl[i].rst; g = tbl[i].g; rdy = tbl[i].rdy;
      sample();
      check($sformatf("tbl%0d_valid", i), 32'(ov), 32'(tbl[i].ev));
      check($sformatf("tbl%0d_data", i), 32'(od), 32'(tbl[i].ed));
      check($sformatf("tbl%0d_ack", i), 32'(ack), 32'(tbl[i].eack));
      check($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].edone));
      check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].eb));
      check($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].ee));
      advance();
    end

    rst = 1'b1; g = 4'h0;
    sample(); advance();
    rst = 1'b0;

    // gnt2 with ready low every other XFER cycle
    n_ack = 0; n_done = 0;
    for (int c = 0; c < 11; c++) begin
      g   = (c < 9) ? 4'b0100 : 4'b0000;
      rdy = (c % 2 == 0);
      d[2] = 8'($urandom);
      sample();
      n_ack  += int'(ack[2]);
      n_done += int'(done[2]);
      advance();
    end
    check("seqA_acks", 32'(n_ack), 32'd4);
    check("seqA_done2", 32'(n_done), 32'd1);

    // gnt1 aborted after two beats, then a clean gnt3 burst
    gs = '{4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 4'h8,
           4'h8, 4'h8, 4'h8, 4'h8, 4'h0, 4'h0};
    rdy = 1'b1; n_done = 0; n_other = 0;
    for (int c = 0; c < 12; c++) begin
      g = gs[c];
      sample();
      if (c == 3) check("seqB_abort_valid", 32'(ov), 32'd0);
      if (c == 4) check("seqB_abort_busy", 32'(busy), 32'd0);
      if (c >= 6 && c <= 9) check("seqB_src3", 32'(osrc), 32'd3);
      n_other += int'(done[1]);
      n_done  += int'(done[3]);
      advance();
    end
    check("seqB_no_done1", 32'(n_other), 32'd0);
    check("seqB_done3", 32'(n_done), 32'd1);
    check("seqB_err", 32'(err), 32'd0);

    // multi-hot grant, then a normal burst with err sticky
    for (int c = 0; c < 9; c++) begin
      g = (c == 0) ? 4'h5 : ((c >= 2 && c <= 6) ? 4'h4 : 4'h0);
      sample();
      if (c == 1) check("seqC_err_set", 32'(err), 32'd1);
      if (c == 1) check("seqC_no_xfer", 32'(busy), 32'd0);
      if (c == 8) check("seqC_err_held", 32'(err), 32'd1);
      advance();
    end
    rst = 1'b1; g = 4'h0;
    sample(); advance();
    rst = 1'b0;
    sample();
    check("seqC_err_clr", 32'(err), 32'd0);
    advance();

    // reset on beat 2, then a full re-grant
    n_ack = 0; n_done = 0; n_other = 0;
    for (int c = 0; c < 11; c++) begin
      g   = (c == 3 || c >= 9) ? 4'h0 : 4'h1;
      rst = (c == 2);
      sample();
      if (c == 3) begin
        check("seqD_rst_valid", 32'(ov), 32'd0);
        check("seqD_rst_data", 32'(od), 32'd0);
        check("seqD_rst_src", 32'(osrc), 32'd0);
        check("seqD_rst_ack", 32'(ack), 32'd0);
        check("seqD_rst_done", 32'(done), 32'd0);
        check("seqD_rst_busy", 32'(busy), 32'd0);
      end
      if (c <= 3) n_other += int'(done[0]);
      if (c >= 4) n_ack   += int'(ack[0]);
      if (c >= 4) n_done  += int'(done[0]);
      advance();
    end
    rst = 1'b0;
    check("seqD_no_done", 32'(n_other), 32'd0);
    check("seqD_acks", 32'(n_ack), 32'd4);
    check("seqD_done0", 32'(n_done), 32'd1);

    // gnt1 held through DONE: back-to-back bursts
    q.delete(); n_done = 0;
    for (int c = 0; c < 13; c++) begin
      g = (c < 11) ? 4'h2 : 4'h0;
      sample();
      if (ack[1]) q.push_back(c);
      n_done += int'(done[1]);
      advance();
    end
    check("seqE_acks", 32'(q.size()), 32'd8);
    if (q.size() == 8) begin
      check("seqE_first_run", 32'(q[3] - q[0]), 32'd3);
      check("seqE_gap", 32'(q[4] - q[3]), 32'd3);
    end
    check("seqE_dones", 32'(n_done), 32'd2);

    // random traffic against the model
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4, 5: g = 4'b0001 << $urandom_range(0, 3);
          6, 7:             g = 4'h0;
          default:          g = 4'($urandom);
        endcase
      end
      rdy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
      sample();
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
